// File: rtl/div_seq_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding,
// default datapath width and iteration-counter sizing.
package div_seq_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One extra bit so the counter can represent WIDTH itself.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/div_seq_comp_32.sv
// WIDTH-bit unsigned magnitude comparator built from cascaded 8-bit slices;
// the most significant slice consumes the external EQ/GT cascade inputs.
module comp_32 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             eq_in,
  input  logic             gt_in,
  output logic             eq_out,
  output logic             gt_out
);

  localparam int SLICES = WIDTH / 8;

  if (WIDTH % 8 != 0) begin : g_width_check
    $error("comp_32: WIDTH must be a multiple of 8");
  end

  // Index SLICES is the cascade input; index 0 is the final result.
  logic [SLICES:0] eq_chain;
  logic [SLICES:0] gt_chain;

  assign eq_chain[SLICES] = eq_in;
  assign gt_chain[SLICES] = gt_in;

  genvar gi;
  for (gi = 0; gi < SLICES; gi++) begin : g_slice
    logic [7:0] a_s;
    logic [7:0] b_s;
    assign a_s = a[gi*8 +: 8];
    assign b_s = b[gi*8 +: 8];
    assign eq_chain[gi] = eq_chain[gi+1] & (a_s == b_s);
    assign gt_chain[gi] = gt_chain[gi+1] | (eq_chain[gi+1] & (a_s > b_s));
  end

  assign eq_out = eq_chain[0];
  assign gt_out = gt_chain[0];

endmodule

// File: rtl/div_seq.sv
// Multicycle signed restoring divider: one quotient bit per clock, operands
// converted to magnitudes at start and signs re-applied in the DONE cycle.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] rem_reg, rem_next;
  logic [WIDTH-1:0] dvd_reg, dvd_next;
  logic [WIDTH-1:0] dsr_reg, dsr_next;
  logic             sign_q_reg, sign_q_next;
  logic             sign_r_reg, sign_r_next;
  logic             dbz_reg, dbz_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic [WIDTH-1:0] remainder_reg, remainder_next;
  logic             exc_reg, exc_next;
  logic             rdy_reg, rdy_next;

  logic [WIDTH-1:0] rem_shift;
  logic [WIDTH-1:0] rem_diff;
  logic             cmp_eq, cmp_gt, ge;

  // Two's-complement magnitude; INT_MIN maps onto itself, which is the
  // correct unsigned value 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

  // Quotient bits are shifted into the low end of the dividend register as
  // dividend bits leave the top, so after WIDTH steps it holds the quotient.
  assign rem_shift = {rem_reg[WIDTH-2:0], dvd_reg[WIDTH-1]};
  assign rem_diff  = rem_shift - dsr_reg;

  comp_32 #(.WIDTH(WIDTH)) u_comp (
    .a      (rem_shift),
    .b      (dsr_reg),
    .eq_in  (1'b1),
    .gt_in  (1'b0),
    .eq_out (cmp_eq),
    .gt_out (cmp_gt)
  );

  assign ge = cmp_eq | cmp_gt;

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    rem_next       = rem_reg;
    dvd_next       = dvd_reg;
    dsr_next       = dsr_reg;
    sign_q_next    = sign_q_reg;
    sign_r_next    = sign_r_reg;
    dbz_next       = dbz_reg;
    result_next    = result_reg;
    remainder_next = remainder_reg;
    exc_next       = exc_reg;
    rdy_next       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (ctrl_DIV) begin
          dvd_next    = mag(data_operandA);
          dsr_next    = mag(data_operandB);
          sign_q_next = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
          sign_r_next = data_operandA[WIDTH-1];
          rem_next    = '0;
          cnt_next    = '0;
          dbz_next    = (data_operandB == '0);
          state_next  = (data_operandB == '0) ? DONE : RUN;
        end
      end

      RUN: begin
        rem_next = ge ? rem_diff : rem_shift;
        dvd_next = {dvd_reg[WIDTH-2:0], ge};
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == CW'(WIDTH - 1)) begin
          state_next = DONE;
        end
      end

      DONE: begin
        rdy_next   = 1'b1;
        state_next = IDLE;
        if (dbz_reg) begin
          exc_next       = 1'b1;
          result_next    = '0;
          remainder_next = '0;
        end else begin
          exc_next       = 1'b0;
          result_next    = sign_q_reg ? (~dvd_reg + 1'b1) : dvd_reg;
          remainder_next = sign_r_reg ? (~rem_reg + 1'b1) : rem_reg;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      rem_reg       <= '0;
      dvd_reg       <= '0;
      dsr_reg       <= '0;
      sign_q_reg    <= 1'b0;
      sign_r_reg    <= 1'b0;
      dbz_reg       <= 1'b0;
      result_reg    <= '0;
      remainder_reg <= '0;
      exc_reg       <= 1'b0;
      rdy_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      rem_reg       <= rem_next;
      dvd_reg       <= dvd_next;
      dsr_reg       <= dsr_next;
      sign_q_reg    <= sign_q_next;
      sign_r_reg    <= sign_r_next;
      dbz_reg       <= dbz_next;
      result_reg    <= result_next;
      remainder_reg <= remainder_next;
      exc_reg       <= exc_next;
      rdy_reg       <= rdy_next;
    end
  end

  assign data_result    = result_reg;
  assign data_remainder = remainder_reg;
  assign data_exception = exc_reg;
  assign data_resultRDY = rdy_reg;
  assign busy           = (state_reg != IDLE);

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Multicycle signed integer divider for the MultDiv unit: one quotient bit per cycle, restoring algorithm.
- Each iteration compares the shifted partial remainder against the divisor. The compare uses the cascaded magnitude-comparator chain (EQ/GT carried in, EQ/GT out).
- Sits between the CPU's MultDiv control (ctrl_DIV pulse, operands) and the writeback mux (result, exception, ready).

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of 8 (comparator built from 8-bit slices).

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- ctrl_DIV  input  1  start strobe; sampled only in IDLE
- data_operandA  input  WIDTH  dividend, two's complement
- data_operandB  input  WIDTH  divisor, two's complement
- data_result  output  WIDTH  quotient, truncated toward zero
- data_remainder  output  WIDTH  remainder, sign of dividend
- data_exception  output  1  divide-by-zero flag
- data_resultRDY  output  1  one-cycle done pulse
- busy  output  1  high in RUN and DONE

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, counter=0.
  - data_result=0, data_remainder=0, data_exception=0, data_resultRDY=0, busy=0.
  - Reset in any state, including mid-RUN, aborts the operation with no RDY pulse.
- States: IDLE, RUN, DONE.
- IDLE, ctrl_DIV=1 at edge E0:
  - Latch |A|, |B|, sign_q = A[W-1]^B[W-1], sign_r = A[W-1].
  - Clear partial remainder R and counter.
  - If B==0: go to DONE directly. At E1, data_exception=1, data_result=0, data_remainder=0.
  - Otherwise go to RUN.
- RUN, one iteration per edge:
  - R' = {R[W-2:0], dividend_msb}; shift the dividend left by one.
  - Compare R' with |B| using the comparator chain, cascade inputs EQ1=1, GT1=0. Condition "ge" = EQ0|GT0.
  - If ge: R = R' - |B| and quotient bit = 1. Otherwise R = R' and quotient bit = 0.
  - Counter increments. After WIDTH iterations (edges E1..E32 for WIDTH=32) go to DONE.
- DONE, for one cycle:
  - data_resultRDY=1.
  - data_result = sign_q ? -Q : Q; data_remainder = sign_r ? -R : R.
  - data_exception=0 unless divide-by-zero.
  - Next edge goes to IDLE.
  - Latency: RDY high in the cycle following edge E(WIDTH+1), i.e. E33 for WIDTH=32; E1 for divide-by-zero.
- Output holding:
  - data_result, data_remainder and data_exception hold their value until the next accepted start.
  - They are registered outputs, not recomputed in IDLE.
  - data_resultRDY is high for exactly one cycle per accepted start.
- ctrl_DIV while in RUN or DONE: ignored, no queueing. The operand buses are don't-care after E0.
- Width/overflow rules:
  - |INT_MIN| is held in a WIDTH-bit unsigned register, so no extra bit is needed.
  - INT_MIN / -1 gives quotient 0x80000000 (wraps), remainder 0, no exception.
- Comparator cascade: MSB slice first, top 8 bits feeding the next slice's EQ1/GT1.

Decomposition:
- Shared package/header:
  - state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2
  - WIDTH default
  - counter width = clog2(WIDTH)+1
- Sub-module: comp_32, the WIDTH-bit magnitude comparator built by chaining 8-bit comparator slices. It is instantiated once, combinationally, on R' vs |B|.
- Negation and subtraction use the team's existing adder.
- Separate FSM module: none; the FSM stays in div_seq.

Test Plan:
- 20 / 3, start at E0: RDY only after E33; result=6, remainder=2, exception=0; busy high E1..E33.
- -20 / 3: result=0xFFFFFFFA (-6), remainder=0xFFFFFFFE (-2); 20 / -3: result=-6, remainder=2.
- 7 / 0: RDY after E1; exception=1, result=0, remainder=0. Next start 9 / 3: result=3, exception cleared.
- ctrl_DIV pulsed again at E5 with new operands during 100 / 7: ignored. Result=14, remainder=2, only one RDY pulse.
- reset asserted at E10 of a run: after that edge state=IDLE and all outputs 0, no RDY. A fresh 15 / 4 then yields 3 rem 3 after 33 edges.
- INT_MIN / -1: result=0x80000000, rem=0, no exception. INT_MIN / 1: 0x80000000. 5 / 7: result 0, rem 5.
